// File: rtl/basilisk_pkg.sv
// Shared types and constants for the basilisk vector writeback path.
package basilisk;

    localparam int BASILISK_OFFSET_ADDR_WIDTH  = 8;
    localparam int BASILISK_REG_ADDR_WIDTH     = 5;
    localparam int BASILISK_RESULT_WIDTH       = 32;
    localparam int BASILISK_WRITEBACK_CHANNELS = 4;

    typedef logic [$clog2(BASILISK_WRITEBACK_CHANNELS)-1:0] basilisk_channel_index_t;

    typedef struct packed {
        logic [BASILISK_REG_ADDR_WIDTH-1:0]    dest_reg_addr;
        logic [BASILISK_OFFSET_ADDR_WIDTH-1:0] dest_offset_addr;
        logic [BASILISK_RESULT_WIDTH-1:0]      result;
    } basilisk_writeback_result_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int basilisk_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/basilisk_writeback_fifo.sv
// Per-channel result FIFO: count, wrapping pointers and storage; depth need not be a power of 2.
module basilisk_writeback_fifo
    import basilisk::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 45
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = basilisk_index_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/basilisk_writeback_arbiter.sv
// Round-robin writeback arbiter: per-channel FIFOs feeding one registered output slot.
// Optional per-channel grant counters when BASILISK_WRITEBACK_COUNTERS_EN is defined.
module basilisk_writeback_arbiter
    import basilisk::*;
#(
    parameter int CHANNELS      = 4,
    parameter int FIFO_DEPTH    = 2,
    parameter int OFFSET_WIDTH  = BASILISK_OFFSET_ADDR_WIDTH,
    localparam int DATA_W = BASILISK_REG_ADDR_WIDTH + OFFSET_WIDTH + BASILISK_RESULT_WIDTH,
    localparam int CH_W   = basilisk_index_width(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        in_valid,
    output logic [CHANNELS-1:0]        in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CH_W-1:0]            out_channel,
    output logic                       idle
`ifdef BASILISK_WRITEBACK_COUNTERS_EN
    ,
    output logic [CHANNELS*32-1:0]     grant_count
`endif
);

    logic [CHANNELS-1:0] fifo_empty;
    logic [CHANNELS-1:0] fifo_full;
    logic [CHANNELS-1:0] fifo_push;
    logic [CHANNELS-1:0] fifo_pop;
    logic [DATA_W-1:0]   fifo_head [CHANNELS];

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_channel_q, out_channel_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                grant_valid;
    logic [CH_W-1:0]     grant_idx;
    logic                out_xfer;
    logic                slot_load;

    for (genvar g = 0; g < CHANNELS; g++) begin : fifo_gen
        basilisk_writeback_fifo #(
            .DEPTH  (FIFO_DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (fifo_push[g]),
            .push_data (in_data[g*DATA_W +: DATA_W]),
            .pop       (fifo_pop[g]),
            .pop_data  (fifo_head[g]),
            .empty     (fifo_empty[g]),
            .full      (fifo_full[g])
        );
    end

    // Ready depends only on the registered count, so a pop never opens room for a same-cycle push.
    assign in_ready  = {CHANNELS{~rst}} & ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign out_valid = out_valid_q & ~rst;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        logic [CH_W-1:0] cand;
        cand        = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        // First non-empty channel at or after rr_ptr_q, wrapping to 0.
        for (int k = 0; k < CHANNELS; k++) begin
            cand = CH_W'((int'(rr_ptr_q) + k) % CHANNELS);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end

        slot_load = grant_valid & (~out_valid_q | out_xfer);

        fifo_pop      = '0;
        out_valid_d   = out_valid_q & ~out_xfer;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        rr_ptr_d      = rr_ptr_q;
        if (slot_load) begin
            fifo_pop[grant_idx] = 1'b1;
            out_valid_d         = 1'b1;
            out_data_d          = fifo_head[grant_idx];
            out_channel_d       = grant_idx;
            rr_ptr_d            = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            rr_ptr_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign idle        = (&fifo_empty) & ~out_valid_q;

`ifdef BASILISK_WRITEBACK_COUNTERS_EN
    logic [31:0] grant_count_q [CHANNELS];
    logic [31:0] grant_count_d [CHANNELS];

    always_comb begin
        grant_count_d = grant_count_q;
        if (out_xfer) grant_count_d[out_channel_q] = grant_count_q[out_channel_q] + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) grant_count_q[i] <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : count_out_gen
        assign grant_count[g*32 +: 32] = grant_count_q[g];
    end
`endif

endmodule
